// File: rtl/alu_pkg.sv
// Shared types and flag bit positions for the ARM32 datapath ALU.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and NZCV flags from two operands and an opcode.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  alu_op_e          i_op,
   output logic [WIDTH-1:0] o_result,
   output logic [3:0]       o_flags
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_result;
   logic             w_c;
   logic             w_v;

   // Operation select; subtraction is A + ~B + 1 so C means "no borrow"
   always_comb begin
      w_sum    = {(WIDTH+1){1'b0}};
      w_result = {WIDTH{1'b0}};
      w_c      = 1'b0;
      w_v      = 1'b0;
      case (i_op)
         ALU_ADD: begin
            w_sum    = {1'b0, i_a} + {1'b0, i_b};
            w_result = w_sum[WIDTH-1:0];
            w_c      = w_sum[WIDTH];
            w_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         ALU_SUB: begin
            w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
            w_result = w_sum[WIDTH-1:0];
            w_c      = w_sum[WIDTH];
            w_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         ALU_AND: begin
            w_result = i_a & i_b;
         end
         ALU_OR: begin
            w_result = i_a | i_b;
         end
         default: begin
            w_result = {WIDTH{1'b0}};
         end
      endcase
   end

   // Flag packing shared by every operation
   always_comb begin
      o_flags         = 4'b0000;
      o_flags[FLAG_N] = w_result[WIDTH-1];
      o_flags[FLAG_Z] = (w_result == {WIDTH{1'b0}});
      o_flags[FLAG_C] = w_c;
      o_flags[FLAG_V] = w_v;
   end

   assign o_result = w_result;

endmodule : alu_core

// File: rtl/alu.sv
// Registered 32-bit ALU with valid pipeline and NZCV flags.
// Optional sticky overflow flag (v_sticky / sticky_clr) enabled by defining ALU_STICKY_V_EN.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef ALU_STICKY_V_EN
   input  logic             sticky_clr,
   output logic             v_sticky,
`endif
   input  logic             in_valid,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [1:0]       ALUControl,
   output logic             out_valid,
   output logic [WIDTH-1:0] ALUResult,
   output logic [3:0]       ALUFlag
);

   logic [WIDTH-1:0] w_result;
   logic [3:0]       w_flags;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_valid;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_a      (SrcA),
      .i_b      (SrcB),
      .i_op     (alu_op_e'(ALUControl)),
      .o_result (w_result),
      .o_flags  (w_flags)
   );

   // Output registers capture only on in_valid, otherwise hold the last result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= {WIDTH{1'b0}};
         r_flags  <= 4'b0000;
         r_valid  <= 1'b0;
      end else if (in_valid) begin
         r_result <= w_result;
         r_flags  <= w_flags;
         r_valid  <= 1'b1;
      end else begin
         r_valid  <= 1'b0;
      end
   end

`ifdef ALU_STICKY_V_EN
   logic r_v_sticky;

   // A new overflow takes priority over a clear in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v_sticky <= 1'b0;
      end else if (in_valid && w_flags[FLAG_V]) begin
         r_v_sticky <= 1'b1;
      end else if (sticky_clr) begin
         r_v_sticky <= 1'b0;
      end else begin
         r_v_sticky <= r_v_sticky;
      end
   end

   assign v_sticky = r_v_sticky;
`endif

   assign out_valid = r_valid;
   assign ALUResult = r_result;
   assign ALUFlag   = r_flags;

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan vectors plus randomized ops against an arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [1:0]  ALUControl;
   logic        out_valid;
   logic [31:0] ALUResult;
   logic [3:0]  ALUFlag;
`ifdef ALU_STICKY_V_EN
   logic        sticky_clr;
   logic        v_sticky;
   logic        exp_sticky;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] hold_r;
   logic [3:0]  hold_f;

   alu #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef ALU_STICKY_V_EN
      .sticky_clr (sticky_clr),
      .v_sticky   (v_sticky),
`endif
      .in_valid   (in_valid),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .out_valid  (out_valid),
      .ALUResult  (ALUResult),
      .ALUFlag    (ALUFlag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact 64-bit arithmetic; C from unsigned range, V when the signed result does not fit
   function automatic logic [35:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint ua, ub, sa, sb, u, s;
      logic [31:0] r;
      logic c, v;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      u = 0; s = 0; c = 1'b0; v = 1'b0;
      case (op)
         2'd0: begin u = ua + ub; s = sa + sb; r = u[31:0]; c = (u > 64'sd4294967295); v = (s != longint'($signed(r))); end
         2'd1: begin u = ua - ub; s = sa - sb; r = u[31:0]; c = (ua >= ub); v = (s != longint'($signed(r))); end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   task automatic check(input string tag, input logic [31:0] er, input logic [3:0] ef, input logic ev);
      total++;
      assert (out_valid === ev) else begin bad++; $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, ev); end
      total++;
      assert (ALUResult === er) else begin bad++; $error("FAIL %s result got=%h exp=%h", tag, ALUResult, er); end
      total++;
      assert (ALUFlag === ef) else begin bad++; $error("FAIL %s flags got=%b exp=%b", tag, ALUFlag, ef); end
   endtask

   task automatic step(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef);
      @(negedge clk);
      in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
      @(posedge clk);
      #1;
      hold_r = er; hold_f = ef;
      check(tag, er, ef, 1'b1);
   endtask

   task automatic idle(input string tag);
      @(negedge clk);
      in_valid = 1'b0; ALUControl = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
      @(posedge clk);
      #1;
      check(tag, hold_r, hold_f, 1'b0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [35:0] m;
      logic [1:0]  op;
      logic [31:0] a, b;
      rst_n = 1'b0; in_valid = 1'b0; SrcA = 32'd0; SrcB = 32'd0; ALUControl = 2'b00;
`ifdef ALU_STICKY_V_EN
      sticky_clr = 1'b0; exp_sticky = 1'b0;
`endif
      hold_r = 32'd0; hold_f = 4'b0000;
      repeat (2) @(posedge clk);
      #1 check("reset", 32'd0, 4'b0000, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // Test-plan vectors, back-to-back
      step("add45", 2'b00, 32'd4, 32'd5, 32'h0000_0009, 4'b0000);
      step("sub45", 2'b01, 32'd4, 32'd5, 32'hFFFF_FFFF, 4'b1000);
      step("and45", 2'b10, 32'd4, 32'd5, 32'h0000_0004, 4'b0000);
      step("or45",  2'b11, 32'd4, 32'd5, 32'h0000_0005, 4'b0000);
      step("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
      step("add_carry", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
      step("sub_eq", 2'b01, 32'd5, 32'd5, 32'h0000_0000, 4'b0110);
      step("sub_ovf", 2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);

      // Single valid then three idle cycles: outputs hold
      step("hold_src", 2'b10, 32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204, 4'b1000);
      idle("hold1");
      idle("hold2");
      idle("hold3");

      // Asynchronous reset mid-cycle with a live result on the outputs
      step("pre_rst", 2'b11, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000);
      #2 rst_n = 1'b0;
      #1 check("async_rst", 32'd0, 4'b0000, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      hold_r = 32'd0; hold_f = 4'b0000;

      // Reset across a valid edge discards it; no result without a fresh in_valid
      @(negedge clk);
      in_valid = 1'b1; ALUControl = 2'b00; SrcA = 32'd7; SrcB = 32'd9; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1 check("discard", 32'd0, 4'b0000, 1'b0);

      // Randomized ops with random valid gaps
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            op = 2'($urandom); a = pick_operand(); b = pick_operand();
            m = ref_alu(op, a, b);
            step("rand", op, a, b, m[31:0], m[35:32]);
         end else begin
            idle("rand_idle");
         end
      end

`ifdef ALU_STICKY_V_EN
      total++;
      assert (v_sticky === 1'b1) else begin bad++; $error("FAIL sticky_after_rand got=%b exp=1", v_sticky); end
      @(negedge clk) sticky_clr = 1'b1; in_valid = 1'b0;
      @(negedge clk) sticky_clr = 1'b0;
      total++;
      assert (v_sticky === 1'b0) else begin bad++; $error("FAIL sticky_clr0 got=%b exp=0", v_sticky); end
      step("st_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
      step("st_plain", 2'b00, 32'd1, 32'd2, 32'd3, 4'b0000);
      total++;
      assert (v_sticky === 1'b1) else begin bad++; $error("FAIL sticky_hold got=%b exp=1", v_sticky); end
      @(negedge clk) sticky_clr = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1 total++;
      assert (v_sticky === 1'b0) else begin bad++; $error("FAIL sticky_clr got=%b exp=0", v_sticky); end
      @(negedge clk) sticky_clr = 1'b1;
      step("st_both", 2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
      total++;
      assert (v_sticky === 1'b1) else begin bad++; $error("FAIL sticky_set_wins got=%b exp=1", v_sticky); end
      sticky_clr = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alu
